result_collector_arbiter: RTL and testbench

//   Merges result streams from NUM_REQ solver cores into one shared result fifo, fair round-robin.

---
 rtl/result_collector_arbiter_pkg.sv | 19 +
 rtl/result_collector_arbiter_if.sv | 28 ++
 rtl/result_collector_arbiter_rr_pick.sv | 30 +++
 rtl/result_collector_arbiter.sv | 60 ++++++
 tb/tb_result_collector_arbiter.sv | 188 ++++++++++++++++++
 5 files changed

// File: rtl/result_collector_arbiter_pkg.sv
// Shared types and constants for the result collector: default widths,
// source-tag width helper and the {src_id, payload} fifo entry layout.
package result_collector_arbiter_pkg;

  localparam int NUM_REQ_DEF = 4;
  localparam int DATA_W_DEF  = 40;

  function automatic int id_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int ID_W_DEF = id_w(NUM_REQ_DEF);

  typedef struct packed {
    logic [ID_W_DEF-1:0]   src_id;
    logic [DATA_W_DEF-1:0] payload;
  } result_t;

endpackage

// File: rtl/result_collector_arbiter_if.sv
// Core-side handshake plus downstream fifo write port. The master modport is
// the arbiter's view; slave is the cores/fifo environment.
interface result_collector_arbiter_if
  import result_collector_arbiter_pkg::*;
#(
  parameter int NUM_REQ        = NUM_REQ_DEF,
  parameter int DATA_W         = DATA_W_DEF,
  parameter int FIFO_ADDR_BITS = 3
);
  localparam int ID_W = id_w(NUM_REQ);

  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        req_ready;
  logic [FIFO_ADDR_BITS:0]   fifo_count;
  logic                      fifo_wen;
  logic [ID_W+DATA_W-1:0]    fifo_wdata;

  modport master (
    input  req_valid, req_data, fifo_count,
    output req_ready, fifo_wen, fifo_wdata
  );

  modport slave (
    output req_valid, req_data, fifo_count,
    input  req_ready, fifo_wen, fifo_wdata
  );
endinterface

// File: rtl/result_collector_arbiter_rr_pick.sv
// Combinational round-robin pick: first set request at or after ptr, wrapping
// explicitly so non-power-of-two request counts never yield an out-of-range id.
module result_collector_arbiter_rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    idx,
  output logic               any
);
  int c;

  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    c     = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      c = int'(ptr) + k;
      if (c >= NUM_REQ) c = c - NUM_REQ;
      if (!any && req[c]) begin
        any      = 1'b1;
        idx      = ID_W'(c);
        grant[c] = 1'b1;
      end
    end
  end
endmodule

// File: rtl/result_collector_arbiter.sv
// Round-robin merge of NUM_REQ result streams into one fifo through a single
// registered write stage; each entry carries its source index.
module result_collector_arbiter
  import result_collector_arbiter_pkg::*;
#(
  parameter int NUM_REQ        = NUM_REQ_DEF,
  parameter int DATA_W         = DATA_W_DEF,
  parameter int FIFO_ADDR_BITS = 3
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       enable,
  result_collector_arbiter_if.master bus,
  output logic [31:0]                accept_cnt,
  output logic                       idle
);
  localparam int ID_W  = id_w(NUM_REQ);
  localparam int CNT_W = FIFO_ADDR_BITS + 2;
  localparam logic [CNT_W-1:0] DEPTH = CNT_W'(2 ** FIFO_ADDR_BITS);

  logic [ID_W-1:0]    ptr;
  logic [ID_W-1:0]    pick_idx;
  logic [NUM_REQ-1:0] pick_grant;
  logic               pick_any;
  logic [CNT_W-1:0]   occ;
  logic               can_issue;
  logic               take;

  result_collector_arbiter_rr_pick #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_pick (
    .req   (bus.req_valid),
    .ptr   (ptr),
    .grant (pick_grant),
    .idx   (pick_idx),
    .any   (pick_any)
  );

  // The in-flight write is counted as occupied; fifo reads are only seen via fifo_count.
  assign occ       = CNT_W'(bus.fifo_count) + CNT_W'(bus.fifo_wen);
  assign can_issue = enable && (occ < DEPTH);
  assign take      = can_issue && pick_any && !reset;

  assign bus.req_ready = take ? pick_grant : '0;
  assign idle          = !(|bus.req_valid) && !bus.fifo_wen;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      bus.fifo_wen   <= 1'b0;
      bus.fifo_wdata <= '0;
      accept_cnt     <= '0;
      ptr            <= '0;
    end else begin
      bus.fifo_wen <= take;
      if (take) begin
        bus.fifo_wdata <= {pick_idx, bus.req_data[int'(pick_idx)*DATA_W +: DATA_W]};
        ptr            <= (pick_idx == ID_W'(NUM_REQ - 1)) ? '0 : pick_idx + ID_W'(1);
        accept_cnt     <= accept_cnt + 32'd1;
      end
    end
  end
endmodule

// File: tb/tb_result_collector_arbiter.sv
// Directed bench: stimulus pushes hand-derived fifo entries into a scoreboard,
// a negedge monitor pops and compares on every fifo write.
module tb_result_collector_arbiter;
  import result_collector_arbiter_pkg::*;

  localparam int N  = 4;
  localparam int DW = 40;
  localparam int AB = 3;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic enable = 1'b1;
  logic [31:0] accept_cnt;
  logic idle;

  logic [N-1:0]         valid = '0;
  logic [N-1:0][DW-1:0] dat;
  logic [AB:0]          fcnt;
  logic                 drain = 1'b1;
  logic                 rd = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;
  result_t sb[$];

  result_collector_arbiter_if #(.NUM_REQ(N), .DATA_W(DW), .FIFO_ADDR_BITS(AB)) bus ();

  result_collector_arbiter #(.NUM_REQ(N), .DATA_W(DW), .FIFO_ADDR_BITS(AB)) dut (
    .clock      (clock),
    .reset      (reset),
    .enable     (enable),
    .bus        (bus),
    .accept_cnt (accept_cnt),
    .idle       (idle)
  );

  assign bus.req_valid  = valid;
  assign bus.req_data   = dat;
  assign bus.fifo_count = fcnt;

  always #5 clock = ~clock;

  // Downstream fifo occupancy model; drain keeps it empty.
  always @(posedge clock or posedge reset) begin
    if (reset)      fcnt <= '0;
    else if (drain) fcnt <= '0;
    else            fcnt <= fcnt + (AB+1)'(bus.fifo_wen) - (AB+1)'(rd);
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push(input int id);
    result_t e;
    e.src_id  = ID_W_DEF'(id);
    e.payload = dat[id];
    sb.push_back(e);
  endtask

  always @(negedge clock) begin
    if (!reset && bus.fifo_wen) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_write: got %0h expected none", bus.fifo_wdata);
      end else begin
        result_t e;
        e = sb.pop_front();
        chk("fifo_wdata", 64'(bus.fifo_wdata), 64'(e));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < N; i++) dat[i] = {8'(8'hA0 + i), 32'h1000_0000 + 32'(i)};
    // Reset with every core valid
    valid = '1;
    @(negedge clock);
    @(negedge clock);
    chk("rst_ready", 64'(bus.req_ready), 64'd0);
    chk("rst_wen", 64'(bus.fifo_wen), 64'd0);
    chk("rst_cnt", 64'(accept_cnt), 64'd0);
    reset = 1'b0;

    // Round robin with drained fifo: 0,1,2,3,0
    for (int k = 0; k < 5; k++) begin
      #1 chk("rr_ready", 64'(bus.req_ready), 64'(4'b0001 << (k % 4)));
      push(k % 4);
      @(negedge clock);
    end
    valid = '0;
    chk("rr_cnt", 64'(accept_cnt), 64'd5);
    chk("rr_idle_busy", 64'(idle), 64'd0);
    @(negedge clock);
    chk("rr_idle", 64'(idle), 64'd1);

    // Fill: core1 streams with no reads -> exactly 8 writes
    drain = 1'b0;
    valid = 4'b0010;
    for (int j = 0; j < 11; j++) begin
      #1 chk(j == 8 ? "full_cnt7_wen1" : "full_ready", 64'(bus.req_ready),
             64'(j < 8 ? 4'b0010 : 4'b0000));
      if (j < 8) push(1);
      if (j == 10) rd = 1'b1;
      @(negedge clock);
    end
    rd = 1'b0;
    #1 chk("cnt7_wen0_grant", 64'(bus.req_ready), 64'(4'b0010));
    push(1);
    @(negedge clock);
    #1 chk("after_one_grant", 64'(bus.req_ready), 64'd0);
    @(negedge clock);
    #1 chk("full_again", 64'(bus.req_ready), 64'd0);
    chk("full_acc", 64'(accept_cnt), 64'd14);
    valid = '0;
    drain = 1'b1;

    // Enable drop right after a grant
    @(negedge clock);
    valid = 4'b1001;
    #1 chk("en_ready", 64'(bus.req_ready), 64'(4'b1000));
    push(3);
    @(negedge clock);
    enable = 1'b0;
    #1 chk("en_off_ready", 64'(bus.req_ready), 64'd0);
    @(negedge clock);
    chk("en_off_wen", 64'(bus.fifo_wen), 64'd0);
    @(negedge clock);
    chk("en_off_wen2", 64'(bus.fifo_wen), 64'd0);
    enable = 1'b1;
    #1 chk("en_on_ready", 64'(bus.req_ready), 64'(4'b0001));
    push(0);
    @(negedge clock);
    valid = '0;
    chk("en_acc", 64'(accept_cnt), 64'd16);
    @(negedge clock);
    chk("en_idle", 64'(idle), 64'd1);

    // Sparse: move ptr to 3 via core2, then core2 again, then core0
    valid = 4'b0100;
    #1 chk("sp_setup", 64'(bus.req_ready), 64'(4'b0100));
    push(2);
    @(negedge clock);
    dat[2] = 40'h5A_DEAD_BEEF;
    #1 chk("sp_core2", 64'(bus.req_ready), 64'(4'b0100));
    push(2);
    @(negedge clock);
    valid = 4'b0001;
    dat[0] = 40'hC3_0BAD_F00D;
    #1 chk("sp_core0", 64'(bus.req_ready), 64'(4'b0001));
    push(0);
    @(negedge clock);
    valid = '0;
    chk("sp_idle_busy", 64'(idle), 64'd0);
    @(negedge clock);
    chk("sp_idle", 64'(idle), 64'd1);
    chk("sp_hold", 64'(bus.fifo_wdata), 64'({2'd0, 40'hC3_0BAD_F00D}));
    chk("sp_acc", 64'(accept_cnt), 64'd19);

    // Reset with a write in flight
    valid = 4'b0010;
    #1 chk("mid_ready", 64'(bus.req_ready), 64'(4'b0010));
    @(posedge clock);
    #1 reset = 1'b1;
    #1 chk("mid_rst_wen", 64'(bus.fifo_wen), 64'd0);
    chk("mid_rst_acc", 64'(accept_cnt), 64'd0);
    chk("mid_rst_ready", 64'(bus.req_ready), 64'd0);
    @(negedge clock);
    valid = '0;
    reset = 1'b0;
    @(negedge clock);
    chk("sb_empty", 64'(sb.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
